// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: fetch PC, credit-limited instruction-memory request
// channel, in-flight PC queue, and a DEPTH-entry {pc, instr} buffer drained by
// decode. A redirect flushes the buffer and arms a drop counter so that
// responses to requests issued before the redirect are discarded.
module fetch_buffer #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     imem_req_valid_o,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr_o,
  input  logic                     imem_req_ready_i,
  input  logic                     imem_rsp_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] imem_rsp_data_i,
  output logic                     instr_valid_o,
  output logic [ADDRESS_WIDTH-1:0] instr_o,
  output logic [ADDRESS_WIDTH-1:0] instr_pc_o,
  input  logic                     instr_ready_i
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] NOP     = AW'(32'h0000_0013);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] buf_pc_q   [DEPTH];
  logic [AW-1:0] buf_data_q [DEPTH];
  logic [AW-1:0] ifq_pc_q   [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0] credit_sum;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_live;
  logic        pop;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // Buffered words plus every outstanding request (stale ones included) must
  // fit in the buffer, so a response can always be accepted.
  assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req_valid  = rst_i && !redirect_i && (credit_sum < DEPTH_L);
  assign req_fire   = req_valid && imem_req_ready_i;
  assign rsp_drop   = imem_rsp_valid_i && (drop_q != '0);
  assign rsp_live   = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
  assign pop        = (count_q != '0) && instr_ready_i && !redirect_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc_q;
  assign instr_valid_o    = (count_q != '0);
  assign instr_o          = instr_valid_o ? buf_data_q[head_q] : NOP;
  assign instr_pc_o       = instr_valid_o ? buf_pc_q[head_q]   : '0;

  // Next-state for PC, pointers and counters; redirect flushes everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    ifq_rd_d      = ifq_rd_q;
    ifq_wr_d      = ifq_wr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_i) begin
      fetch_pc_d    = {redirect_pc_i[AW-1:2], 2'b00};
      head_d        = '0;
      tail_d        = '0;
      ifq_rd_d      = '0;
      ifq_wr_d      = '0;
      count_d       = '0;
      // Everything still in flight is stale; a response arriving now is
      // discarded on the spot and does not need a drop credit.
      outstanding_d = outstanding_q - CW'(imem_rsp_valid_i);
      drop_d        = outstanding_q - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + AW'(4);
        ifq_wr_d   = ifq_wr_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_live) begin
        ifq_rd_d = ifq_rd_q + PW'(1);
        tail_d   = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      count_d       = count_q + CW'(rsp_live) - CW'(pop);
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      ifq_rd_q      <= '0;
      ifq_wr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      ifq_rd_q      <= ifq_rd_d;
      ifq_wr_q      <= ifq_wr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      assert (!imem_rsp_valid_i || (outstanding_q != '0));
    end
  end

  // Storage arrays carry only data, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      ifq_pc_q[ifq_wr_q] <= fetch_pc_q;
    end
    if (rst_i && rsp_live) begin
      buf_pc_q[tail_q]   <= ifq_pc_q[ifq_rd_q];
      buf_data_q[tail_q] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a variable-latency in-order memory, an epoch-tagged
// behavioural model of the buffer checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i, redirect_i, imem_req_ready_i, imem_rsp_valid_i, instr_ready_i;
  logic [31:0] redirect_pc_i, imem_rsp_data_i;
  logic        imem_req_valid_o, instr_valid_o;
  logic [31:0] imem_req_addr_o, instr_o, instr_pc_o;

  logic        w_rsp_valid, w_req_valid, w_instr_valid;
  logic [31:0] w_rsp_data, w_req_addr, w_instr, w_instr_pc;
  logic        w_fire_prev;

  always #5 clk_i = ~clk_i;

  fetch_buffer #(.ADDRESS_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i));

  fetch_buffer #(.ADDRESS_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_valid_o(w_req_valid), .imem_req_addr_o(w_req_addr),
    .imem_req_ready_i(1'b1), .imem_rsp_valid_i(w_rsp_valid),
    .imem_rsp_data_i(w_rsp_data), .instr_valid_o(w_instr_valid),
    .instr_o(w_instr), .instr_pc_o(w_instr_pc), .instr_ready_i(1'b1));

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        memq[$];
  logic [31:0] bufq[$];
  logic [31:0] exp_addr;
  int          epoch, last_due, cyc;
  bit          started;
  int          total, bad;
  int          rdy_pct, irdy_pct, lat_fix;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0F};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the edge.
  req_t        h;
  int          d, lat;
  logic        erv;
  always @(negedge clk_i) begin
    if (started) begin
      erv = rst_i && !redirect_i && ((bufq.size() + memq.size()) < DEPTH);
      chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, erv});
      chk("req_addr", imem_req_addr_o, exp_addr);
      chk("instr_valid", {31'b0, instr_valid_o}, (bufq.size() > 0) ? 32'd1 : 32'd0);
      if (bufq.size() > 0) begin
        chk("instr_pc", instr_pc_o, bufq[0]);
        chk("instr", instr_o, mem_word(bufq[0]));
      end else begin
        chk("idle_pc", instr_pc_o, 32'h0);
        chk("idle_instr", instr_o, NOP);
      end
    end
    if (!rst_i) begin
      memq.delete();
      bufq.delete();
      epoch++;
      exp_addr = 32'h0;
      last_due = 0;
      started  = 1'b1;
    end else if (started) begin
      erv = !redirect_i && ((bufq.size() + memq.size()) < DEPTH);
      if (bufq.size() > 0 && instr_ready_i && !redirect_i) void'(bufq.pop_front());
      if (imem_rsp_valid_i) begin
        if (memq.size() == 0) begin
          chk("rsp_without_req", 32'd1, 32'd0);
        end else begin
          h = memq.pop_front();
          if (h.ep == epoch && !redirect_i) bufq.push_back(h.addr);
        end
      end
      if (bufq.size() > DEPTH) chk("overflow", bufq.size(), DEPTH);
      if (redirect_i) begin
        bufq.delete();
        epoch++;
        exp_addr = {redirect_pc_i[31:2], 2'b00};
      end else if (erv && imem_req_ready_i) begin
        lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(5, 1));
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{addr: exp_addr, due: d, ep: epoch});
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  task automatic step(input bit rst_v, input bit redir, input logic [31:0] rpc);
    @(posedge clk_i);
    cyc++;
    #1;
    rst_i            = rst_v;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = ($urandom_range(99) < rdy_pct);
    instr_ready_i    = ($urandom_range(99) < irdy_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = $urandom;
    end
    w_rsp_valid = w_fire_prev;
    w_rsp_data  = $urandom;
    #1;
    w_fire_prev = rst_v && w_req_valid;
  endtask

  logic [31:0] fa[4], wa[4], pa[4];
  int          fc[4];
  int          nf, wn, np, fv, ffi;
  logic [31:0] fpc, ffa;

  initial begin
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    instr_ready_i = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_fire_prev = 1'b0;
    total = 0; bad = 0; epoch = 0; cyc = 0; started = 1'b0; last_due = 0;
    exp_addr = '0;

    // Reset, then fill with decode stalled (latency 1).
    rdy_pct = 100; irdy_pct = 0; lat_fix = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t1_rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("t1_rst_addr", imem_req_addr_o, 32'h0);
    chk("t1_rst_instr", instr_o, NOP);
    chk("t5_rst_addr", w_req_addr, 32'hFFFF_FFF8);
    nf = 0; wn = 0; fv = -1; fpc = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      if (w_req_valid && wn < 4) begin wa[wn] = w_req_addr; wn++; end
      if (imem_req_valid_o && imem_req_ready_i) begin
        if (nf < 4) begin fa[nf] = imem_req_addr_o; fc[nf] = i; end
        nf++;
      end
      if (instr_valid_o && fv < 0) begin fv = i; fpc = instr_pc_o; end
    end
    chk("t2_req_count", nf, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", fa[k], 32'(4 * k));
      chk("t1_back_to_back", fc[k], k);
    end
    chk("t1_first_valid_delay", fv, 2);
    chk("t1_first_pc", fpc, 32'h0);
    chk("t2_stalled", {31'b0, imem_req_valid_o}, 32'd0);
    chk("t5_wrap0", wa[0], 32'hFFFF_FFF8);
    chk("t5_wrap1", wa[1], 32'hFFFF_FFFC);
    chk("t5_wrap2", wa[2], 32'h0000_0000);
    chk("t5_wrap3", wa[3], 32'h0000_0004);

    // Release back-pressure: drain in order, fetching resumes at 0x10.
    irdy_pct = 100; nf = 0; np = 0; ffa = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      if (imem_req_valid_o && imem_req_ready_i && nf == 0) begin ffa = imem_req_addr_o; nf++; end
      if (instr_valid_o && instr_ready_i && np < 4) begin pa[np] = instr_pc_o; np++; end
    end
    chk("t2_resume_addr", ffa, 32'h10);
    for (int k = 0; k < 4; k++) chk("t2_pop_order", pa[k], 32'(4 * k));

    // Redirect with three requests in flight (latency 4).
    lat_fix = 4;
    step(0, 0, 0);
    ffi = -1; fv = -1; ffa = '0; fpc = '0;
    for (int i = 0; i < 14; i++) begin
      step(1, i == 3, 32'h0000_0103);
      if (i > 3 && ffi < 0 && imem_req_valid_o && imem_req_ready_i) begin ffi = i; ffa = imem_req_addr_o; end
      if (i > 3 && fv < 0 && instr_valid_o) begin fv = i; fpc = instr_pc_o; end
    end
    chk("t3_new_addr", ffa, 32'h100);
    chk("t3_new_issue_cycle", ffi, 4);
    chk("t3_first_valid_cycle", fv, 9);
    chk("t3_first_pc", fpc, 32'h100);

    // Redirect coinciding with a response and a pop request (latency 2).
    lat_fix = 2; irdy_pct = 0;
    step(0, 0, 0);
    ffi = -1; fv = -1; ffa = '0; fpc = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) irdy_pct = 100;
      step(1, i == 4, 32'h0000_0200);
      if (i == 4) chk("t4_valid_before", {31'b0, instr_valid_o}, 32'd1);
      if (i == 5) chk("t4_flushed", {31'b0, instr_valid_o}, 32'd0);
      if (i > 4 && ffi < 0 && imem_req_valid_o && imem_req_ready_i) begin ffi = i; ffa = imem_req_addr_o; end
      if (i > 4 && fv < 0 && instr_valid_o) begin fv = i; fpc = instr_pc_o; end
    end
    chk("t4_new_addr", ffa, 32'h200);
    chk("t4_new_issue_cycle", ffi, 5);
    chk("t4_first_valid_cycle", fv, 8);
    chk("t4_first_pc", fpc, 32'h200);

    // Random traffic: latency 1-5, random ready, stalls, redirects, resets.
    lat_fix = 0; rdy_pct = 70; irdy_pct = 60;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(199));
      step(r != 0, (r > 0) && (r < 10), $urandom);
    end
    step(1, 0, 0);
    step(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
